pck_flit_injector: RTL and testbench

PCK_FLIT_INJECTOR -- requirements
Module: pck_flit_injector

---
 rtl/pck_flit_injector.sv | 186 ++++++++++++++++++
 tb/tb_pck_flit_injector.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pck_flit_injector.sv
// Packet-to-flit injector: turns one packet request plus a body data stream into
// header/body/tail flits on a one-hot VC, gated by per-VC downstream credits.
module pck_flit_injector #(
    parameter int V            = 4,
    parameter int Fw           = 36,
    parameter int FPAYw        = 30,
    parameter int EAw          = 4,
    parameter int DAw          = 4,
    parameter int DSTPw        = 3,
    parameter int Cw           = 1,
    parameter int B            = 4,
    parameter int MAX_PCK_SIZE = 16,
    parameter int PSw          = $clog2(MAX_PCK_SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pck_valid,
    output logic             pck_ready,
    input  logic [EAw-1:0]   src_e_addr_in,
    input  logic [DAw-1:0]   dest_e_addr_in,
    input  logic [DSTPw-1:0] destport_in,
    input  logic [Cw-1:0]    class_in,
    input  logic [V-1:0]     vc_num_in,
    input  logic [PSw-1:0]   pck_size_in,
    input  logic [FPAYw-1:0] data_in,
    input  logic             data_in_valid,
    output logic             data_in_ready,
    output logic [Fw-1:0]    flit_out,
    output logic             flit_out_wr,
    input  logic [V-1:0]     credit_in,
    output logic             busy,
    output logic             credit_err
);

    localparam int CRw = $clog2(B + 1);
    localparam int HW  = Cw + DSTPw + DAw + EAw;

    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

    state_t           state_q, state_d;
    logic [EAw-1:0]   src_q, src_d;
    logic [DAw-1:0]   dest_q, dest_d;
    logic [DSTPw-1:0] dport_q, dport_d;
    logic [Cw-1:0]    cls_q, cls_d;
    logic [V-1:0]     vc_q, vc_d;
    logic [PSw-1:0]   size_q, size_d;
    logic [PSw-1:0]   rem_q, rem_d;
    logic [CRw-1:0]   credit_q [V];
    logic [CRw-1:0]   credit_d [V];
    logic             credit_err_q, credit_err_d;
    logic [Fw-1:0]    flit_q, flit_d;
    logic             wr_q, wr_d;

    logic             cred_ok;
    logic             issue;
    logic [FPAYw-1:0] hdr_pay;

    // Zero means "one flit" (header only); oversize requests are truncated.
    function automatic logic [PSw-1:0] clamp_size(input logic [PSw-1:0] s);
        if (s == '0)
            return PSw'(1);
        else if (s > PSw'(MAX_PCK_SIZE))
            return PSw'(MAX_PCK_SIZE);
        else
            return s;
    endfunction

    always_comb begin
        cred_ok = 1'b0;
        for (int v = 0; v < V; v++) begin
            if (vc_q[v] && (credit_q[v] != '0))
                cred_ok = 1'b1;
        end
    end

    always_comb begin
        hdr_pay         = '0;
        hdr_pay[HW-1:0] = {cls_q, dport_q, dest_q, src_q};
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dest_d       = dest_q;
        dport_d      = dport_q;
        cls_d        = cls_q;
        vc_d         = vc_q;
        size_d       = size_q;
        rem_d        = rem_q;
        flit_d       = flit_q;
        issue        = 1'b0;
        credit_err_d = credit_err_q;
        for (int v = 0; v < V; v++)
            credit_d[v] = credit_q[v];

        case (state_q)
            IDLE: begin
                if (pck_valid) begin
                    src_d   = src_e_addr_in;
                    dest_d  = dest_e_addr_in;
                    dport_d = destport_in;
                    cls_d   = class_in;
                    vc_d    = vc_num_in;
                    size_d  = clamp_size(pck_size_in);
                    state_d = HDR;
                end
            end
            HDR: begin
                if (cred_ok) begin
                    issue  = 1'b1;
                    flit_d = {1'b1, (size_q == PSw'(1)), vc_q, hdr_pay};
                    if (size_q == PSw'(1)) begin
                        state_d = IDLE;
                    end else begin
                        rem_d   = size_q - PSw'(1);
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (data_in_valid && cred_ok) begin
                    issue  = 1'b1;
                    flit_d = {1'b0, (rem_q == PSw'(1)), vc_q, data_in};
                    rem_d  = rem_q - PSw'(1);
                    if (rem_q == PSw'(1))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_d = issue;

        // A return and an issue on the same VC cancel; a lone return at B is an overflow.
        for (int v = 0; v < V; v++) begin
            if (credit_in[v] && !(issue && vc_q[v])) begin
                if (credit_q[v] == CRw'(B))
                    credit_err_d = 1'b1;
                else
                    credit_d[v] = credit_q[v] + CRw'(1);
            end else if (!credit_in[v] && issue && vc_q[v]) begin
                credit_d[v] = credit_q[v] - CRw'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dest_q       <= '0;
            dport_q      <= '0;
            cls_q        <= '0;
            vc_q         <= '0;
            size_q       <= '0;
            rem_q        <= '0;
            flit_q       <= '0;
            wr_q         <= 1'b0;
            credit_err_q <= 1'b0;
            for (int v = 0; v < V; v++)
                credit_q[v] <= CRw'(B);
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dest_q       <= dest_d;
            dport_q      <= dport_d;
            cls_q        <= cls_d;
            vc_q         <= vc_d;
            size_q       <= size_d;
            rem_q        <= rem_d;
            flit_q       <= flit_d;
            wr_q         <= wr_d;
            credit_err_q <= credit_err_d;
            for (int v = 0; v < V; v++)
                credit_q[v] <= credit_d[v];
        end
    end

    assign pck_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign data_in_ready = (state_q == BODY) && cred_ok;
    assign flit_out      = flit_q;
    assign flit_out_wr   = wr_q;
    assign credit_err    = credit_err_q;

endmodule

// File: tb/tb_pck_flit_injector.sv
// Randomized bench for pck_flit_injector: a packet-level model fills an expected-flit
// queue, a monitor pops and compares every written flit and returns credits.
module tb_pck_flit_injector;

    localparam int V     = 4;
    localparam int FPAYw = 30;
    localparam int Fw    = 2 + V + FPAYw;
    localparam int EAw   = 4;
    localparam int DAw   = 4;
    localparam int DSTPw = 3;
    localparam int Cw    = 1;
    localparam int B     = 2;
    localparam int MAXP  = 16;
    localparam int PSw   = $clog2(MAXP + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             pck_valid;
    logic             pck_ready;
    logic [EAw-1:0]   src_e_addr_in;
    logic [DAw-1:0]   dest_e_addr_in;
    logic [DSTPw-1:0] destport_in;
    logic [Cw-1:0]    class_in;
    logic [V-1:0]     vc_num_in;
    logic [PSw-1:0]   pck_size_in;
    logic [FPAYw-1:0] data_in;
    logic             data_in_valid;
    logic             data_in_ready;
    logic [Fw-1:0]    flit_out;
    logic             flit_out_wr;
    logic [V-1:0]     credit_in;
    logic             busy;
    logic             credit_err;

    always #5 clk = ~clk;

    pck_flit_injector #(
        .V(V), .Fw(Fw), .FPAYw(FPAYw), .EAw(EAw), .DAw(DAw), .DSTPw(DSTPw),
        .Cw(Cw), .B(B), .MAX_PCK_SIZE(MAXP), .PSw(PSw)
    ) dut (
        .clk(clk), .reset(reset), .pck_valid(pck_valid), .pck_ready(pck_ready),
        .src_e_addr_in(src_e_addr_in), .dest_e_addr_in(dest_e_addr_in),
        .destport_in(destport_in), .class_in(class_in), .vc_num_in(vc_num_in),
        .pck_size_in(pck_size_in), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
        .credit_in(credit_in), .busy(busy), .credit_err(credit_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [Fw-1:0]    exp_q[$];
    logic [FPAYw-1:0] body_q[$];
    logic [Fw-1:0]    rf_q[$];
    int               rc_q[$];
    int               recv_cnt = 0;
    int               cyc = 0;
    int               outstanding[V];
    bit               cred_auto = 1'b1;
    int               cred_prob = 60;
    int               dv_prob   = 70;
    logic [V-1:0]     force_cred = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [Fw-1:0] mk_flit(input bit h, input bit t,
                                              input logic [V-1:0] vc,
                                              input logic [FPAYw-1:0] p);
        return {h, t, vc, p};
    endfunction

    // Monitor: scoreboard compare, credit-discipline check, downstream credit returns.
    initial begin
        credit_in = '0;
        for (int v = 0; v < V; v++) outstanding[v] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                credit_in = '0;
                for (int v = 0; v < V; v++) outstanding[v] = 0;
            end else begin
                if (flit_out_wr) begin
                    recv_cnt++;
                    rc_q.push_back(cyc);
                    rf_q.push_back(flit_out);
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_flit: got %0h, expected none", flit_out);
                    end else begin
                        check("flit", 64'(flit_out), 64'(exp_q.pop_front()));
                    end
                    for (int v = 0; v < V; v++) begin
                        if (flit_out[FPAYw+v]) begin
                            outstanding[v]++;
                            if (outstanding[v] > B) begin
                                n_total++;
                                $display("FAIL credit_overrun vc%0d: in flight %0d, limit %0d",
                                         v, outstanding[v], B);
                            end
                        end
                    end
                end
                for (int v = 0; v < V; v++) begin
                    logic c;
                    c = force_cred[v];
                    if (!c && cred_auto && outstanding[v] > 0 &&
                        $urandom_range(99) < cred_prob)
                        c = 1'b1;
                    if (c) outstanding[v]--;
                    credit_in[v] = c;
                end
            end
        end
    end

    // Body data source: presents the head payload, pops it on a handshake.
    initial begin
        data_in_valid = 1'b0;
        data_in       = '0;
        forever begin
            @(negedge clk);
            if (!reset || body_q.size() == 0) begin
                data_in_valid = 1'b0;
            end else begin
                data_in       = body_q[0];
                data_in_valid = ($urandom_range(99) < dv_prob);
                if (data_in_valid && data_in_ready)
                    void'(body_q.pop_front());
            end
        end
    end

    task automatic randomize_fields();
        src_e_addr_in  = EAw'($urandom);
        dest_e_addr_in = DAw'($urandom);
        destport_in    = DSTPw'($urandom);
        class_in       = Cw'($urandom);
        vc_num_in      = V'($urandom);
        pck_size_in    = PSw'($urandom);
    endtask

    task automatic send_pck(input int size, input logic [V-1:0] vc,
                            input int s, input int d, input int dp, input int cl,
                            input bit fixed, input logic [FPAYw-1:0] p0,
                            input logic [V-1:0] fc);
        int n;
        int w;
        logic [FPAYw-1:0] hp;
        logic [FPAYw-1:0] p;
        w = 0;
        @(negedge clk);
        while (!pck_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!pck_ready) begin
            n_total++;
            $display("FAIL request_timeout: pck_ready %0b, expected 1", pck_ready);
            return;
        end
        src_e_addr_in  = EAw'(s);
        dest_e_addr_in = DAw'(d);
        destport_in    = DSTPw'(dp);
        class_in       = Cw'(cl);
        vc_num_in      = vc;
        pck_size_in    = PSw'(size);
        pck_valid      = 1'b1;
        n  = (size == 0) ? 1 : ((size > MAXP) ? MAXP : size);
        hp = FPAYw'(s + d * (1 << EAw) + dp * (1 << (EAw + DAw)) + cl * (1 << (EAw + DAw + DSTPw)));
        exp_q.push_back(mk_flit(1'b1, n == 1, vc, hp));
        for (int i = 1; i < n; i++) begin
            p = fixed ? FPAYw'(p0 + FPAYw'(i - 1)) : FPAYw'($urandom);
            body_q.push_back(p);
            exp_q.push_back(mk_flit(1'b0, i == n - 1, vc, p));
        end
        @(posedge clk);
        #1;
        pck_valid = 1'b0;
        randomize_fields();
        force_cred = fc;
        @(posedge clk);
        #1;
        force_cred = '0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(pck_ready && exp_q.size() == 0 && body_q.size() == 0) && w < 3000) begin
            @(negedge clk);
            #2;
            w++;
        end
        if (w >= 3000) begin
            n_total++;
            $display("FAIL idle_timeout: %0d flits still expected, expected 0", exp_q.size());
        end
    endtask

    task automatic drain();
        cred_auto = 1'b1;
        cred_prob = 100;
        wait_idle();
        repeat (5) @(negedge clk);
        #2;
    endtask

    task automatic wait_recv(input int target);
        int w;
        w = 0;
        while (recv_cnt < target && w < 200) begin
            @(negedge clk);
            #2;
            w++;
        end
    endtask

    initial begin
        int base;
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset      = 1'b0;
        pck_valid  = 1'b0;
        randomize_fields();
        #1;
        check("rst_pck_ready", 64'(pck_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_in_ready", 64'(data_in_ready), 64'd0);
        check("rst_flit_out_wr", 64'(flit_out_wr), 64'd0);
        check("rst_flit_out", 64'(flit_out), 64'd0);
        check("rst_credit_err", 64'(credit_err), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Random packets: sizes 0..20, random VC, body stalls and credit returns.
        cred_auto = 1'b1;
        cred_prob = 60;
        dv_prob   = 70;
        for (int k = 0; k < 25; k++)
            send_pck($urandom_range(20), V'(1 << $urandom_range(V - 1)),
                     $urandom_range(15), $urandom_range(15), $urandom_range(7),
                     $urandom_range(1), 1'b0, '0, '0);
        wait_idle();

        // Three-flit reference packet with full throughput.
        drain();
        dv_prob = 100;
        rc_q.delete();
        rf_q.delete();
        base = recv_cnt;
        send_pck(3, 4'b0010, 5, 9, 0, 0, 1'b1, 30'hA, '0);
        wait_recv(base + 3);
        check("ref_busy_after_tail", 64'(busy), 64'd0);
        check("ref_ready_after_tail", 64'(pck_ready), 64'd1);
        check("ref_hdr_payload", 64'(rf_q[0][FPAYw-1:0]), 64'h95);
        check("ref_hdr_flags", 64'(rf_q[0][Fw-1:Fw-2]), 64'b10);
        check("ref_tail_payload", 64'(rf_q[2][FPAYw-1:0]), 64'hB);
        check("ref_tail_flags", 64'(rf_q[2][Fw-1:Fw-2]), 64'b01);
        check("ref_gap_1", 64'(rc_q[1] - rc_q[0]), 64'd1);
        check("ref_gap_2", 64'(rc_q[2] - rc_q[1]), 64'd1);

        // Single-flit packets, size 1 and size 0, back to back.
        base = recv_cnt;
        send_pck(1, 4'b1000, 3, 4, 5, 1, 1'b0, '0, '0);
        send_pck(0, 4'b1000, 3, 4, 5, 1, 1'b0, '0, '0);
        wait_idle();
        check("single_flit_count", 64'(recv_cnt - base), 64'd2);

        // Toggling body valid.
        dv_prob = 50;
        send_pck(8, 4'b0001, 1, 2, 3, 0, 1'b0, '0, '0);
        wait_idle();
        dv_prob = 100;

        // Credit exhaustion stall, then one credit releases exactly one flit.
        drain();
        cred_auto = 1'b0;
        base = recv_cnt;
        send_pck(4, 4'b0010, 7, 6, 1, 0, 1'b0, '0, '0);
        repeat (20) @(negedge clk);
        #2;
        check("stall_count", 64'(recv_cnt - base), 64'd2);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_data_in_ready", 64'(data_in_ready), 64'd0);
        @(posedge clk);
        #1;
        force_cred = 4'b0010;
        @(posedge clk);
        #1;
        force_cred = '0;
        repeat (10) @(negedge clk);
        #2;
        check("one_credit_count", 64'(recv_cnt - base), 64'd3);
        cred_auto = 1'b1;
        wait_idle();

        // Credit return coinciding with the header issue leaves the count unchanged.
        drain();
        cred_auto = 1'b0;
        base = recv_cnt;
        send_pck(4, 4'b0100, 2, 2, 2, 1, 1'b0, '0, 4'b0100);
        repeat (20) @(negedge clk);
        #2;
        check("simul_count", 64'(recv_cnt - base), 64'd3);
        check("simul_credit_err", 64'(credit_err), 64'd0);
        cred_auto = 1'b1;
        wait_idle();

        // Credit return at full credit is an overflow and sticks.
        drain();
        cred_auto = 1'b0;
        @(posedge clk);
        #1;
        force_cred = 4'b0001;
        @(posedge clk);
        #1;
        force_cred = '0;
        repeat (2) @(negedge clk);
        check("credit_err_set", 64'(credit_err), 64'd1);
        repeat (5) @(negedge clk);
        check("credit_err_sticky", 64'(credit_err), 64'd1);

        // Reset in the middle of a 5-flit packet.
        base = recv_cnt;
        send_pck(5, 4'b0001, 9, 8, 7, 1, 1'b0, '0, '0);
        wait_recv(base + 2);
        check("mid_pkt_wr", 64'(flit_out_wr), 64'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_wr", 64'(flit_out_wr), 64'd0);
        check("mid_rst_flit_out", 64'(flit_out), 64'd0);
        check("mid_rst_pck_ready", 64'(pck_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data_in_ready", 64'(data_in_ready), 64'd0);
        check("mid_rst_credit_err", 64'(credit_err), 64'd0);
        exp_q.delete();
        body_q.delete();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        base = recv_cnt;
        repeat (6) @(negedge clk);
        #2;
        check("no_flit_after_reset", 64'(recv_cnt - base), 64'd0);
        send_pck(3, 4'b0010, 4, 3, 2, 1, 1'b0, '0, '0);
        repeat (15) @(negedge clk);
        #2;
        check("credits_restored", 64'(recv_cnt - base), 64'd2);
        cred_auto = 1'b1;
        wait_idle();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
